// File: rtl/ysyx_22040759_ifu_pcgen.sv
// -----------------------------------------------------------------------------
// ysyx_22040759_ifu_pcgen
//
// Fetch PC generator with a one-entry instruction buffer.
//
// Owns the architectural fetch PC and issues one instruction-fetch request at
// a time on a valid/ready request/response bus. The returned word is held in
// a single buffer and offered to the ID stage. A redirect from the execute
// stage (br_taken / bru_pc) kills the buffered wrong-path instruction, throws
// away any response still in flight and restarts fetch at the branch target.
//
// State machine:
//   REQ  : request presented. The address is held until the memory side
//          accepts it.
//   WAIT : request accepted, waiting for its response (if_rsp_ready=1).
//   HOLD : instruction buffered and offered to ID.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high reset; dominates all other inputs
//   br_taken      one-cycle redirect request from execute
//   bru_pc[63:0]  redirect target, sampled while br_taken=1
//   if_req_valid  fetch request valid (REQ only)
//   if_req_ready  fetch request accepted by memory side
//   if_req_addr   fetch address, word aligned
//   if_rsp_valid  fetch response valid
//   if_rsp_ready  response accepted (WAIT only)
//   if_rsp_data   fetched instruction word
//   if_rsp_err    bus error on this response
//   id_valid      instruction valid to ID
//   id_ready      ID accepts the instruction
//   id_pc         PC of id_inst (full 64 bits, low bits as stored)
//   id_inst       instruction word
//   id_excp       instruction-access fault flag for id_inst
// -----------------------------------------------------------------------------
module ysyx_22040759_ifu_pcgen #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,

  // Redirect from execute
  input  logic        br_taken,
  input  logic [63:0] bru_pc,

  // Fetch request channel
  output logic        if_req_valid,
  input  logic        if_req_ready,
  output logic [63:0] if_req_addr,

  // Fetch response channel
  input  logic        if_rsp_valid,
  output logic        if_rsp_ready,
  input  logic [31:0] if_rsp_data,
  input  logic        if_rsp_err,

  // Instruction to ID
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_excp
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] REQ  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q,    state_d;
  logic [63:0] pc_q,       pc_d;
  logic        drop_q,     drop_d;      // in-flight response belongs to a killed path
  logic [63:0] tgt_q,      tgt_d;       // pending redirect target while drop_q=1
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        excp_buf_q, excp_buf_d;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers (internal, not reset-gated; reset wins in the
  // sequential block anyway)
  // ---------------------------------------------------------------------------
  logic in_req;
  logic in_wait;
  logic in_hold;
  logic req_fire;
  logic rsp_fire;
  logic id_fire;

  assign in_req   = (state_q == REQ);
  assign in_wait  = (state_q == WAIT);
  assign in_hold  = (state_q == HOLD);

  assign req_fire = in_req  && if_req_ready;
  assign rsp_fire = in_wait && if_rsp_valid;
  // A redirect kills the buffered instruction in the same cycle, so no ID
  // handshake may complete while br_taken is high.
  assign id_fire  = in_hold && !br_taken && id_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    tgt_d      = tgt_q;
    inst_buf_d = inst_buf_q;
    excp_buf_d = excp_buf_q;

    case (state_q)
      REQ: begin
        // The pending request is completed unchanged even on a redirect;
        // its response is discarded later and fetch restarts at tgt.
        if (br_taken) begin
          drop_d = 1'b1;
          tgt_d  = bru_pc;
        end
        if (req_fire) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (rsp_fire) begin
          if (drop_q || br_taken) begin
            // Wrong-path response: throw it away and restart at the newest
            // target (a same-cycle redirect beats the stored one).
            pc_d    = br_taken ? bru_pc : tgt_q;
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_buf_d = if_rsp_data;
            excp_buf_d = if_rsp_err;
            state_d    = HOLD;
          end
        end else if (br_taken) begin
          // Latest redirect wins if several arrive before the response.
          drop_d = 1'b1;
          tgt_d  = bru_pc;
        end
      end

      HOLD: begin
        if (br_taken) begin
          pc_d    = bru_pc;
          state_d = REQ;
        end else if (id_fire) begin
          pc_d    = pc_q + 64'd4;   // wraps at 2^64
          state_d = REQ;
        end
      end

      default: begin
        state_d = REQ;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers (reset)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers (no reset)
  // ---------------------------------------------------------------------------
  // NOTE: these hold payload only; nothing reads them unless the control
  // state says they were written, so they are left out of the reset.
  always_ff @(posedge clock) begin
    tgt_q      <= tgt_d;
    inst_buf_q <= inst_buf_d;
    excp_buf_q <= excp_buf_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs: all forced to zero during the reset cycle
  // ---------------------------------------------------------------------------
  assign if_req_valid = !reset && in_req;
  assign if_req_addr  = reset ? 64'd0 : {pc_q[63:2], 2'b00};
  assign if_rsp_ready = !reset && in_wait;

  assign id_valid     = !reset && in_hold && !br_taken;
  assign id_pc        = reset ? 64'd0 : pc_q;
  assign id_inst      = reset ? 32'd0 : inst_buf_q;
  assign id_excp      = !reset && excp_buf_q;

endmodule

// File: tb/tb_ysyx_22040759_ifu_pcgen.sv
// -----------------------------------------------------------------------------
// tb_ysyx_22040759_ifu_pcgen
//
// Single-process bench: every cycle goes through tick(), which samples the
// handshakes just before the rising edge, runs a small memory model after it
// and pops the expected-instruction scoreboard on every ID handshake.
// Scenario tasks push expected instructions and drive br_taken, if_req_ready,
// id_ready and reset, checking other outputs inline.
// -----------------------------------------------------------------------------
module tb_ysyx_22040759_ifu_pcgen;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        br_taken;
  logic [63:0] bru_pc;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        id_excp;

  ysyx_22040759_ifu_pcgen #(.RESET_PC(RESET_PC)) dut (
    .clock        (clock),
    .reset        (reset),
    .br_taken     (br_taken),
    .bru_pc       (bru_pc),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_err   (if_rsp_err),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_excp      (id_excp)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        excp;
  } exp_t;

  exp_t sb_q[$];
  int   id_cyc[$];

  int vecs = 0;
  int errs = 0;
  int cyc_n = 0;

  // Memory model knobs and state
  int          mem_lat   = 1;
  logic        mem_err   = 1'b0;
  logic        mem_flush = 1'b0;
  logic        mem_pending = 1'b0;
  int          mem_cnt   = 0;
  logic [63:0] mem_addr  = 64'd0;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic push_exp(input logic [63:0] pc, input logic excp);
    exp_t e;
    e.pc   = pc;
    e.inst = inst_of({pc[63:2], 2'b00});
    e.excp = excp;
    sb_q.push_back(e);
  endtask

  // One clock cycle: sample before the edge, update memory after it, return
  // on the following falling edge.
  task automatic tick();
    logic        req_hs;
    logic        rsp_hs;
    logic        id_hs;
    logic [63:0] a;
    exp_t        e;
    #1;
    req_hs = if_req_valid && if_req_ready;
    rsp_hs = if_rsp_valid && if_rsp_ready;
    id_hs  = id_valid && id_ready;
    a      = if_req_addr;

    if (req_hs) begin
      vecs++;
      if (mem_pending || (if_rsp_valid && !rsp_hs)) begin
        errs++;
        $display("FAIL outstanding: request at %h while one in flight (got 2, required 1)", a);
      end
    end

    if (id_hs) begin
      vecs++;
      id_cyc.push_back(cyc_n);
      if (sb_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_id: got handshake pc=%h inst=%h, required none", id_pc, id_inst);
      end else begin
        e = sb_q.pop_front();
        if (id_pc !== e.pc || id_inst !== e.inst || id_excp !== e.excp) begin
          errs++;
          $display("FAIL id_data: got pc=%h inst=%h excp=%b, required pc=%h inst=%h excp=%b",
                   id_pc, id_inst, id_excp, e.pc, e.inst, e.excp);
        end
      end
    end

    @(posedge clock);
    #1;
    if (rsp_hs || mem_flush) begin
      if_rsp_valid = 1'b0;
    end
    if (mem_flush) begin
      mem_pending = 1'b0;
      mem_flush   = 1'b0;
    end
    if (req_hs) begin
      mem_pending = 1'b1;
      mem_cnt     = mem_lat;
      mem_addr    = a;
    end
    if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        if_rsp_valid = 1'b1;
        if_rsp_data  = inst_of(mem_addr);
        if_rsp_err   = mem_err;
        mem_pending  = 1'b0;
      end
    end
    cyc_n++;
    @(negedge clock);
  endtask

  task automatic wait_sb_empty(input int budget, input string name);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    vecs++;
    if (sb_q.size() != 0) begin
      errs++;
      $display("FAIL %s_timeout: got %0d instructions pending, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_id_valid(input int budget, input string name);
    for (int i = 0; i < budget && !id_valid; i++) tick();
    vecs++;
    if (id_valid !== 1'b1) begin
      errs++;
      $display("FAIL %s_id_timeout: got id_valid=%b, required 1", name, id_valid);
    end
  endtask

  task automatic wait_req(input int budget, input string name);
    for (int i = 0; i < budget && !if_req_valid; i++) tick();
    vecs++;
    if (if_req_valid !== 1'b1) begin
      errs++;
      $display("FAIL %s_req_timeout: got if_req_valid=%b, required 1", name, if_req_valid);
    end
  endtask

  // Stop the memory side accepting once the DUT is back in REQ.
  task automatic park();
    if_req_ready = 1'b0;
    id_ready     = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    #1;
    vecs++;
    if (if_req_valid !== 1'b0 || if_rsp_ready !== 1'b0 || id_valid !== 1'b0 ||
        if_req_addr !== 64'd0 || id_pc !== 64'd0 || id_excp !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs: got req_v=%b rsp_r=%b id_v=%b addr=%h id_pc=%h excp=%b, required all 0",
               if_req_valid, if_rsp_ready, id_valid, if_req_addr, id_pc, id_excp);
    end
    tick();
    reset = 1'b0;
    #1;
    vecs++;
    if (if_req_valid !== 1'b1 || if_req_addr !== RESET_PC || id_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: got req_v=%b addr=%h id_v=%b, required 1 %h 0",
               if_req_valid, if_req_addr, id_valid, RESET_PC);
    end
  endtask

  task automatic test_free_run();
    int c0;
    c0 = cyc_n;
    id_cyc.delete();
    for (int i = 0; i < 3; i++) push_exp(RESET_PC + 64'(4 * i), 1'b0);
    mem_lat      = 1;
    if_req_ready = 1'b1;
    id_ready     = 1'b1;
    wait_sb_empty(40, "free_run");
    park();
    vecs++;
    if (id_cyc.size() != 3) begin
      errs++;
      $display("FAIL free_run_count: got %0d handshakes, required 3", id_cyc.size());
    end else begin
      vecs++;
      if (id_cyc[0] - c0 != 2) begin
        errs++;
        $display("FAIL free_run_first_latency: got %0d cycles, required 2", id_cyc[0] - c0);
      end
      for (int i = 1; i < 3; i++) begin
        vecs++;
        if (id_cyc[i] - id_cyc[i-1] != 3) begin
          errs++;
          $display("FAIL free_run_period: got %0d cycles, required 3", id_cyc[i] - id_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    if_req_ready = 1'b1;
    id_ready     = 1'b0;
    wait_id_valid(10, "backpressure");
    if_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if (id_valid !== 1'b1 || id_pc !== RESET_PC + 64'hC ||
          id_inst !== inst_of(RESET_PC + 64'hC) || if_req_valid !== 1'b0) begin
        errs++;
        $display("FAIL backpressure_hold: got id_v=%b pc=%h inst=%h req_v=%b, required 1 %h %h 0",
                 id_valid, id_pc, id_inst, if_req_valid, RESET_PC + 64'hC, inst_of(RESET_PC + 64'hC));
      end
    end
    push_exp(RESET_PC + 64'hC, 1'b0);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    #1;
    vecs++;
    if (sb_q.size() != 0 || if_req_valid !== 1'b1 || if_req_addr !== RESET_PC + 64'h10) begin
      errs++;
      $display("FAIL backpressure_advance: got pending=%0d req_v=%b addr=%h, required 0 1 %h",
               sb_q.size(), if_req_valid, if_req_addr, RESET_PC + 64'h10);
    end
    sb_q.delete();
  endtask

  task automatic test_redirect_hold();
    if_req_ready = 1'b1;
    id_ready     = 1'b0;
    wait_id_valid(10, "redirect_hold");
    if_req_ready = 1'b0;
    vecs++;
    if (id_pc !== RESET_PC + 64'h10) begin
      errs++;
      $display("FAIL redirect_hold_pc: got %h, required %h", id_pc, RESET_PC + 64'h10);
    end
    br_taken = 1'b1;
    bru_pc   = 64'h8000_0100;
    id_ready = 1'b1;
    #1;
    vecs++;
    if (id_valid !== 1'b0) begin
      errs++;
      $display("FAIL redirect_hold_kill: got id_valid=%b, required 0", id_valid);
    end
    tick();
    br_taken = 1'b0;
    id_ready = 1'b0;
    #1;
    vecs++;
    if (if_req_valid !== 1'b1 || if_req_addr !== 64'h8000_0100) begin
      errs++;
      $display("FAIL redirect_hold_target: got req_v=%b addr=%h, required 1 80000100",
               if_req_valid, if_req_addr);
    end
    push_exp(64'h8000_0100, 1'b0);
    if_req_ready = 1'b1;
    id_ready     = 1'b1;
    wait_sb_empty(20, "redirect_hold");
    park();
  endtask

  task automatic test_redirect_wait();
    mem_lat      = 4;
    if_req_ready = 1'b1;
    id_ready     = 1'b1;
    tick();
    if_req_ready = 1'b0;
    #1;
    vecs++;
    if (if_rsp_ready !== 1'b1 || if_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL redirect_wait_state: got rsp_r=%b req_v=%b, required 1 0", if_rsp_ready, if_req_valid);
    end
    br_taken = 1'b1;
    bru_pc   = 64'h8000_0200;
    tick();
    br_taken = 1'b0;
    wait_req(12, "redirect_wait");
    vecs++;
    if (if_req_addr !== 64'h8000_0200) begin
      errs++;
      $display("FAIL redirect_wait_target: got %h, required 80000200", if_req_addr);
    end
    mem_lat = 1;
    push_exp(64'h8000_0200, 1'b0);
    if_req_ready = 1'b1;
    wait_sb_empty(20, "redirect_wait");
    park();
  endtask

  task automatic test_redirect_req();
    if_req_ready = 1'b0;
    br_taken     = 1'b1;
    bru_pc       = 64'h8000_0280;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if (if_req_valid !== 1'b1 || if_req_addr !== 64'h8000_0204) begin
        errs++;
        $display("FAIL redirect_req_stable: got req_v=%b addr=%h, required 1 80000204",
                 if_req_valid, if_req_addr);
      end
      tick();
      br_taken = 1'b0;
    end
    if_req_ready = 1'b1;
    mem_lat      = 3;
    #1;
    vecs++;
    if (if_req_valid !== 1'b1 || if_req_addr !== 64'h8000_0204) begin
      errs++;
      $display("FAIL redirect_req_accept: got req_v=%b addr=%h, required 1 80000204",
               if_req_valid, if_req_addr);
    end
    tick();
    if_req_ready = 1'b0;
    br_taken     = 1'b1;
    bru_pc       = 64'h8000_0300;
    #1;
    vecs++;
    if (if_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL redirect_req_wait: got req_v=%b, required 0", if_req_valid);
    end
    tick();
    br_taken = 1'b0;
    id_ready = 1'b1;
    wait_req(12, "redirect_req");
    vecs++;
    if (if_req_addr !== 64'h8000_0300) begin
      errs++;
      $display("FAIL redirect_req_target: got %h, required 80000300", if_req_addr);
    end
    mem_lat = 1;
    push_exp(64'h8000_0300, 1'b0);
    if_req_ready = 1'b1;
    wait_sb_empty(20, "redirect_req");
    park();
  endtask

  task automatic test_error_reset();
    mem_err = 1'b1;
    push_exp(64'h8000_0304, 1'b1);
    if_req_ready = 1'b1;
    id_ready     = 1'b1;
    wait_sb_empty(20, "error");
    park();
    mem_err = 1'b0;

    mem_lat      = 3;
    if_req_ready = 1'b1;
    tick();
    if_req_ready = 1'b0;
    #1;
    vecs++;
    if (if_rsp_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_wait_state: got rsp_r=%b, required 1", if_rsp_ready);
    end
    reset = 1'b1;
    #1;
    vecs++;
    if (if_req_valid !== 1'b0 || if_rsp_ready !== 1'b0 || id_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_outputs: got req_v=%b rsp_r=%b id_v=%b, required 0 0 0",
               if_req_valid, if_rsp_ready, id_valid);
    end
    tick();
    reset = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if (if_rsp_ready !== 1'b0 || id_valid !== 1'b0 || if_req_valid !== 1'b1 ||
          if_req_addr !== RESET_PC) begin
        errs++;
        $display("FAIL reset_stale_ignored: got rsp_r=%b id_v=%b req_v=%b addr=%h, required 0 0 1 %h",
                 if_rsp_ready, id_valid, if_req_valid, if_req_addr, RESET_PC);
      end
      tick();
    end
    mem_flush = 1'b1;
    tick();
    mem_lat = 1;
    push_exp(RESET_PC, 1'b0);
    if_req_ready = 1'b1;
    wait_sb_empty(20, "reset_restart");
    park();
  endtask

  task automatic test_redirect_wrap();
    if_req_ready = 1'b1;
    id_ready     = 1'b0;
    wait_id_valid(10, "wrap");
    if_req_ready = 1'b0;
    br_taken     = 1'b1;
    bru_pc       = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    vecs++;
    if (id_valid !== 1'b0) begin
      errs++;
      $display("FAIL wrap_kill: got id_valid=%b, required 0", id_valid);
    end
    tick();
    br_taken = 1'b0;
    #1;
    vecs++;
    if (if_req_valid !== 1'b1 || if_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errs++;
      $display("FAIL wrap_align: got req_v=%b addr=%h, required 1 fffffffffffffffc",
               if_req_valid, if_req_addr);
    end
    push_exp(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    if_req_ready = 1'b1;
    id_ready     = 1'b1;
    wait_sb_empty(20, "wrap");
    park();
    #1;
    vecs++;
    if (if_req_valid !== 1'b1 || if_req_addr !== 64'd0) begin
      errs++;
      $display("FAIL wrap_next: got req_v=%b addr=%h, required 1 0", if_req_valid, if_req_addr);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset        = 1'b1;
    br_taken     = 1'b0;
    bru_pc       = 64'd0;
    if_req_ready = 1'b0;
    id_ready     = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_data  = 32'd0;
    if_rsp_err   = 1'b0;
    @(negedge clock);

    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_hold();
    test_redirect_wait();
    test_redirect_req();
    test_error_reset();
    test_redirect_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_22040759_ifu_pcgen.md
Name: ysyx_22040759_ifu_pcgen

Overview:
Fetch-side consumer of the execute-stage branch redirect (br_taken / bru_pc). It owns the architectural fetch PC and issues single-outstanding instruction fetch requests on a valid/ready request/response bus. It buffers one returned instruction for the ID stage. On a redirect it kills the wrong-path instruction, discards in-flight responses and restarts fetch at the branch target.

Parameters:
RESET_PC, 64'h8000_0000, first fetch address after reset

Ports:
clock       input   1   system clock
reset       input   1   synchronous, active-high reset
br_taken    input   1   redirect request from execute stage, valid for one cycle
bru_pc      input   64  redirect target, sampled when br_taken=1
if_req_valid output 1   fetch request valid
if_req_ready input  1   fetch request accepted by memory side
if_req_addr output  64  fetch address; bits[1:0] always 0
if_rsp_valid input  1   fetch response valid
if_rsp_ready output 1   high only in WAIT
if_rsp_data input   32  fetched instruction
if_rsp_err  input   1   bus error on this response
id_valid    output  1   instruction valid to ID
id_ready    input   1   ID accepts instruction
id_pc       output  64  PC of id_inst
id_inst     output  32  instruction word
id_excp     output  1   instruction-access fault flag for id_inst

Behaviour:
- States: REQ (present request), WAIT (request accepted, awaiting response), HOLD (instruction buffered for ID).
- Registers: pc, state, drop, tgt (64), inst_buf, excp_buf.
- Reset (synchronous, dominates all other inputs):
  - state=REQ, pc=RESET_PC, drop=0, all outputs 0 in the reset cycle.
  - if_req_valid first asserts in the cycle after reset deasserts.
  - Reset mid-transaction abandons the in-flight request. Any response arriving after reset is ignored until the next WAIT.
- REQ:
  - if_req_valid=1, if_req_addr={pc[63:2],2'b00}.
  - Address held stable while valid && !ready.
  - Handshake (valid&&ready) -> WAIT.
- WAIT:
  - if_rsp_ready=1.
  - On if_rsp_valid with drop=0 and br_taken=0: inst_buf=if_rsp_data, excp_buf=if_rsp_err -> HOLD.
  - On if_rsp_valid with drop=1 or br_taken=1: discard the data. pc = br_taken ? bru_pc : tgt. Clear drop -> REQ.
- HOLD:
  - id_valid = !br_taken (combinational kill; no ID handshake can occur on a redirect cycle).
  - id_pc=pc, id_inst=inst_buf, id_excp=excp_buf.
  - id_valid && id_ready: pc=pc+4 (64-bit wrap, no overflow flag) -> REQ.
  - br_taken: pc=bru_pc -> REQ; the buffered instruction is dropped.
- Redirect while REQ or WAIT:
  - drop=1, tgt=bru_pc.
  - In REQ the pending request is still completed unchanged (address stability rule), then its response is discarded.
  - Redirect in the same cycle as a REQ handshake sets drop the same way.
- Multiple redirects before the discard completes: latest bru_pc wins (tgt overwritten).
- bru_pc bits[1:0] are stored as-is. Bits[1:0] are zeroed only on if_req_addr; id_pc carries the full value.
- Exactly one outstanding request at any time. if_req_valid=0 in WAIT and HOLD.
- Unexpected if_rsp_valid outside WAIT is ignored (if_rsp_ready=0).
- Latency, zero-wait memory with ready=1 and rsp the next cycle:
  - 2 cycles from REQ entry to HOLD.
  - 3 cycles per instruction at sustained id_ready=1.

Test Plan:
- Reset then free-run: memory always ready, 1-cycle response, id_ready=1 -> id_pc sequence 0x80000000, 0x80000004, 0x80000008, one instruction every 3 cycles, id_excp=0.
- Backpressure: id_ready=0 for 5 cycles in HOLD -> id_valid, id_pc and id_inst stable; if_req_valid=0 throughout; pc advances by 4 only after the handshake.
- Redirect in HOLD: br_taken=1, bru_pc=0x80000100 while id_valid -> id_valid=0 that cycle, no handshake; next request addr=0x80000100.
- Redirect in WAIT with 4-cycle response latency: br_taken=1, bru_pc=0x80000200 -> response discarded, id_valid never asserts for it; next if_req_addr=0x80000200.
- Redirect in REQ with if_req_ready=0 for 3 cycles -> if_req_addr held at old pc until accepted; response discarded; then fetch from target. Second redirect (0x80000300) before the response -> fetch from 0x80000300.
- Error and reset: if_rsp_err=1 -> id_excp=1 with matching id_pc. Reset asserted during WAIT, then a stale response arrives during the following REQ -> ignored; fetch restarts at 0x80000000.
